systolic_array: RTL and testbench
=================================

# systolic_array

Output-stationary systolic matrix multiplier with a single streaming word interface. It loads matrix A (array_height_p × array_width_p) and matrix B (array_width_p × array_width_p) word-serially, computes C = A × B on an array_height_p × array_width_p grid of MAC processing elements (PEs), and streams C out row-major. It sits between a word-level input FIFO/deserializer and a result consumer, using valid/ready on the input side and valid/yumi on the output side.

## Interface

- width_p, default 8: element width of A, B, and the data_i/data_o words.
- array_width_p, default 8: PE columns; the inner dimension K; columns of B and C.
- array_height_p, default 8: PE rows; rows of A and C.

- clk_i  input  1  clock; all state on rising edge.
- reset_i  input  1  reset, asynchronous, active-low.
- en_i  input  1  global enable; low freezes all state.
- flush_i  input  1  end of load; starts computation.
- valid_i  input  1  data_i valid.
- data_i  input  width_p  A/B element, unsigned.
- ready_o  output  1  block accepts data_i this cycle.
- valid_o  output  1  data_o holds a C element.
- data_o  output  width_p  C element, low width_p bits.
- yumi_i  input  1  consumer takes data_o this cycle; legal only when valid_o=1.

## Operation

- Let H=array_height_p, W=array_width_p, NA=H·W, NB=W·W.
- States:
  - LOAD: reset state. Entered with A/B buffers and all accumulators zero.
  - COMPUTE
  - DRAIN
- LOAD:
  - A word is accepted when en_i & valid_i & ready_o.
  - Words 0..NA-1 fill A row-major (A[i][k], k fastest). Words NA..NA+NB-1 fill B row-major (B[k][j]).
  - ready_o = en_i & (state==LOAD) & (count < NA+NB).
  - Once full, ready_o=0 and the block waits for flush_i.
  - en_i & flush_i → COMPUTE, regardless of fill level. Unloaded entries stay zero.
  - If valid_i and flush_i are both high in the same cycle, the word is accepted first, then the state moves to COMPUTE.
- COMPUTE (skewed systolic feed):
  - At compute step t, A[i][k] enters row i at the left edge when t = i+k. B[k][j] enters column j at the top edge when t = j+k.
  - Each PE forwards its A operand right and its B operand down, one register per hop.
  - PE(i,j) meets A[i][k] and B[k][j] at step i+j+k and does acc += a·b.
  - Accumulator width is ≥ 2·width_p + clog2(W), unsigned.
  - COMPUTE lasts exactly H+2W-2 enabled cycles, then → DRAIN.
- DRAIN:
  - Emit C[i][j] row-major (j fastest), H·W elements total.
  - data_o = acc[width_p-1:0], i.e. modulo 2^width_p.
  - Each element is held stable with valid_o=1 until en_i & yumi_i, then the next element is presented.
  - After the last yumi, clear the A/B buffers, accumulators and counters → LOAD.
- Ignored inputs:
  - flush_i in COMPUTE or DRAIN.
  - valid_i whenever ready_o=0.
  - yumi_i whenever valid_o=0.
- en_i=0 freezes:
  - No input is accepted; ready_o=0.
  - The state, counters, PE pipelines and accumulators all hold.
  - valid_o and data_o hold their values; yumi_i is ignored.

## Timing

- Reset (reset_i low, asynchronous): state=LOAD, ready_o=0, valid_o=0, data_o=0, buffers, accumulators and counters 0.
- After reset release, ready_o=1 in the first cycle with en_i=1.
- Input throughput: 1 word/cycle; full load takes NA+NB accepted cycles (128 for 8×8).
- Latency: flush sampled at edge N → valid_o first high after edge N+H+2W-2, assuming en_i stays high. For 8×8 that is 22 cycles.
- Output throughput: 1 element/cycle with yumi_i held high. With yumi_i low, data_o/valid_o are unchanged.
- data_o is registered; the next element appears the cycle after a yumi.
- Reset mid-operation (any state) returns to LOAD immediately with the reset values above. Partially loaded or computed data is discarded.
- After the final yumi, valid_o=0 and ready_o=1 on the next cycle (if en_i=1); a new load may start immediately.

## Test plan

- Identity:
  - A = I (8×8), B[k][j] = 8k+j.
  - Load 128 words, flush → 64 outputs, each equal to B row-major (0..63), first valid_o 22 cycles after flush.
- All-ones: A=B=1 everywhere → every C element = 8.
- Wrap:
  - A=B=255 everywhere → acc = 8·65025 = 0x7F008.
  - Every data_o = 0x08.
- Partial load:
  - Load only 64 words (A random), flush → 64 zeros (B all zero).
  - ready_o stays 1 during the load. With no flush, ready_o drops after word 128.
- Backpressure/enable:
  - In DRAIN, hold yumi_i=0 for 5 cycles → data_o and valid_o are stable.
  - Drop en_i for 3 cycles mid-COMPUTE → valid_o first rises 3 cycles later than the nominal 22.
  - flush_i pulsed in DRAIN has no effect.
- Reset mid-DRAIN:
  - Assert reset_i low after 10 outputs → valid_o=0 immediately.
  - After release, ready_o=1. A fresh identity run then produces correct results.

Source files
------------

// File: rtl/systolic_array.sv
// Output-stationary systolic matrix multiplier: loads A (H x W) and B (W x W) word-serially,
// computes C = A x B on an H x W grid of MAC cells, then streams C out row-major.
module systolic_array #(
    parameter int width_p        = 8,
    parameter int array_width_p  = 8,
    parameter int array_height_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    input  logic               flush_i,
    input  logic               valid_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               valid_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int H     = array_height_p;
    localparam int W     = array_width_p;
    localparam int NA    = H * W;
    localparam int NB    = W * W;
    localparam int NT    = NA + NB;
    localparam int STEPS = H + 2 * W - 2;
    localparam int PW    = 2 * width_p;
    localparam int AW    = PW + $clog2(W);
    localparam int CW    = $clog2(NT + 1);
    localparam int SW    = $clog2(STEPS + 1);
    localparam int IW    = $clog2(NA + 1);

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [SW-1:0]      step_q, step_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic               valid_q, valid_d;
    logic [width_p-1:0] data_q, data_d;

    logic [width_p-1:0] a_buf_q [NA];
    logic [width_p-1:0] a_buf_d [NA];
    logic [width_p-1:0] b_buf_q [NB];
    logic [width_p-1:0] b_buf_d [NB];
    // Per-PE operand registers, flat index i*W+j.
    logic [width_p-1:0] a_pipe_q [NA];
    logic [width_p-1:0] a_pipe_d [NA];
    logic [width_p-1:0] b_pipe_q [NA];
    logic [width_p-1:0] b_pipe_d [NA];
    logic [AW-1:0]      acc_q [NA];
    logic [AW-1:0]      acc_d [NA];

    logic [width_p-1:0] inj_a [H];
    logic [width_p-1:0] inj_b [W];
    logic [width_p-1:0] a_in [NA];
    logic [width_p-1:0] b_in [NA];
    logic [PW-1:0]      prod [NA];
    logic [AW-1:0]      acc_sum [NA];
    logic               accept;

    assign ready_o = reset_i & en_i & (state_q == ST_LOAD) & (cnt_q < CW'(NT));
    assign accept  = valid_i & ready_o;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    // Skewed edge feed: A[i][k] enters row i at step i+k, B[k][j] enters column j at step j+k.
    always_comb begin
        for (int i = 0; i < H; i++) begin
            inj_a[i] = '0;
            for (int k = 0; k < W; k++) begin
                if (step_q == SW'(i + k)) inj_a[i] = a_buf_q[i*W+k];
            end
        end
        for (int j = 0; j < W; j++) begin
            inj_b[j] = '0;
            for (int k = 0; k < W; k++) begin
                if (step_q == SW'(j + k)) inj_b[j] = b_buf_q[k*W+j];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < H; i++) begin
            a_in[i*W] = inj_a[i];
            for (int j = 1; j < W; j++) a_in[i*W+j] = a_pipe_q[i*W+j-1];
        end
        for (int j = 0; j < W; j++) begin
            b_in[j] = inj_b[j];
            for (int i = 1; i < H; i++) b_in[i*W+j] = b_pipe_q[(i-1)*W+j];
        end
        for (int n = 0; n < NA; n++) begin
            prod[n]    = {{width_p{1'b0}}, a_in[n]} * {{width_p{1'b0}}, b_in[n]};
            acc_sum[n] = acc_q[n] + AW'(prod[n]);
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        step_d   = step_q;
        idx_d    = idx_q;
        valid_d  = valid_q;
        data_d   = data_q;
        a_buf_d  = a_buf_q;
        b_buf_d  = b_buf_q;
        a_pipe_d = a_pipe_q;
        b_pipe_d = b_pipe_q;
        acc_d    = acc_q;

        if (en_i) begin
            case (state_q)
                ST_LOAD: begin
                    if (accept) begin
                        for (int n = 0; n < NA; n++) begin
                            if (cnt_q == CW'(n)) a_buf_d[n] = data_i;
                        end
                        for (int n = 0; n < NB; n++) begin
                            if (cnt_q == CW'(NA + n)) b_buf_d[n] = data_i;
                        end
                        cnt_d = cnt_q + CW'(1);
                    end
                    if (flush_i) begin
                        state_d = ST_COMPUTE;
                        step_d  = '0;
                    end
                end
                ST_COMPUTE: begin
                    a_pipe_d = a_in;
                    b_pipe_d = b_in;
                    acc_d    = acc_sum;
                    step_d   = step_q + SW'(1);
                    // The final MACs land on this edge, so present C[0][0] from the sums.
                    if (step_q == SW'(STEPS - 1)) begin
                        state_d = ST_DRAIN;
                        idx_d   = '0;
                        valid_d = 1'b1;
                        data_d  = acc_sum[0][width_p-1:0];
                    end
                end
                ST_DRAIN: begin
                    if (yumi_i) begin
                        if (idx_q == IW'(NA - 1)) begin
                            state_d = ST_LOAD;
                            cnt_d   = '0;
                            step_d  = '0;
                            idx_d   = '0;
                            valid_d = 1'b0;
                            data_d  = '0;
                            for (int n = 0; n < NA; n++) begin
                                a_buf_d[n]  = '0;
                                a_pipe_d[n] = '0;
                                b_pipe_d[n] = '0;
                                acc_d[n]    = '0;
                            end
                            for (int n = 0; n < NB; n++) b_buf_d[n] = '0;
                        end else begin
                            idx_d = idx_q + IW'(1);
                            for (int n = 1; n < NA; n++) begin
                                if (idx_q == IW'(n - 1)) data_d = acc_q[n][width_p-1:0];
                            end
                        end
                    end
                end
                default: state_d = ST_LOAD;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
            step_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            for (int n = 0; n < NA; n++) begin
                a_buf_q[n]  <= '0;
                a_pipe_q[n] <= '0;
                b_pipe_q[n] <= '0;
                acc_q[n]    <= '0;
            end
            for (int n = 0; n < NB; n++) b_buf_q[n] <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            step_q   <= step_d;
            idx_q    <= idx_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            a_buf_q  <= a_buf_d;
            b_buf_q  <= b_buf_d;
            a_pipe_q <= a_pipe_d;
            b_pipe_q <= b_pipe_d;
            acc_q    <= acc_d;
        end
    end

endmodule

// File: tb/tb_systolic_array.sv
// Directed bench for systolic_array (8x8): table of load/compute/drain scenarios with
// hand-computed expectations plus stall, enable-gap and mid-drain reset sequences.
module tb_systolic_array;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       en_i;
    logic       flush_i;
    logic       valid_i;
    logic [7:0] data_i;
    logic       ready_o;
    logic       valid_o;
    logic [7:0] data_o;
    logic       yumi_i;

    always #5 clk_i = ~clk_i;

    systolic_array #(
        .width_p       (8),
        .array_width_p (8),
        .array_height_p(8)
    ) dut (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .en_i   (en_i),
        .flush_i(flush_i),
        .valid_i(valid_i),
        .data_i (data_i),
        .ready_o(ready_o),
        .valid_o(valid_o),
        .data_o (data_o),
        .yumi_i (yumi_i)
    );

    int n_vec  = 0;
    int n_fail = 0;

    // Matrix kinds: 0 zero, 1 identity, 2 ones, 3 all-255, 4 random, 5 8r+c, 6 (r+c)%16.
    // Expect modes: 0 every element = exp_val, 1 element n = n, 2 reference matmul.
    typedef struct {
        int a_kind;
        int b_kind;
        int n_words;
        int exp_mode;
        int exp_val;
        int en_gap;
        int hold;
        int abort_at;
        bit chk_full;
    } case_t;

    case_t cases[10];
    int    ma[8][8];
    int    mb[8][8];

    task automatic check(input string name, input logic [31:0] act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int mat_val(input int kind, input int r, input int c);
        case (kind)
            1:       return (r == c) ? 1 : 0;
            2:       return 1;
            3:       return 255;
            4:       return int'($urandom_range(0, 255));
            5:       return 8 * r + c;
            6:       return (r + c) % 16;
            default: return 0;
        endcase
    endfunction

    function automatic int expect_elem(input case_t c, input int n);
        int i, j, s, av, bv;
        if (c.exp_mode == 0) return c.exp_val;
        if (c.exp_mode == 1) return n;
        i = n / 8;
        j = n % 8;
        s = 0;
        for (int k = 0; k < 8; k++) begin
            av = (i * 8 + k < c.n_words) ? ma[i][k] : 0;
            bv = (64 + k * 8 + j < c.n_words) ? mb[k][j] : 0;
            s += av * bv;
        end
        return s % 256;
    endfunction

    task automatic run_case(input case_t c);
        int bad, lat, exp0, w;
        for (int r = 0; r < 8; r++) begin
            for (int q = 0; q < 8; q++) begin
                ma[r][q] = mat_val(c.a_kind, r, q);
                mb[r][q] = mat_val(c.b_kind, r, q);
            end
        end

        bad = 0;
        for (w = 0; w < c.n_words; w++) begin
            @(negedge clk_i);
            valid_i = 1'b1;
            data_i  = (w < 64) ? 8'(ma[w/8][w%8]) : 8'(mb[(w-64)/8][(w-64)%8]);
            #1;
            if (ready_o !== 1'b1) bad++;
            @(posedge clk_i);
        end
        @(negedge clk_i);
        valid_i = 1'b0;
        check("ready_during_load", bad, 0);

        // A full buffer must refuse further words, even one offered alongside flush.
        if (c.chk_full) begin
            #1;
            check("ready_when_full", ready_o, 0);
            valid_i = 1'b1;
            data_i  = 8'hAA;
        end
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        valid_i = 1'b0;

        lat = 0;
        while (lat <= 100) begin
            if (c.en_gap > 0 && lat == 5) en_i = 1'b0;
            if (c.en_gap > 0 && lat == 5 + c.en_gap) en_i = 1'b1;
            @(posedge clk_i);
            #1;
            lat++;
            if (valid_o === 1'b1) break;
        end
        en_i = 1'b1;
        check("first_valid_latency", lat, 22 + c.en_gap);

        exp0 = expect_elem(c, 0);
        for (int n = 0; n < 64; n++) begin
            @(negedge clk_i);
            if (c.abort_at > 0 && n == c.abort_at) begin
                yumi_i  = 1'b0;
                reset_i = 1'b0;
                #1;
                check("valid_in_reset", valid_o, 0);
                check("data_in_reset", data_o, 0);
                @(posedge clk_i);
                @(negedge clk_i);
                reset_i = 1'b1;
                #1;
                check("ready_after_reset", ready_o, 1);
                return;
            end
            check("valid_in_drain", valid_o, 1);
            check("c_elem", data_o, expect_elem(c, n));
            if (n == 0 && c.hold > 0) begin
                yumi_i  = 1'b0;
                flush_i = 1'b1;
                for (int h = 0; h < c.hold; h++) begin
                    @(posedge clk_i);
                    @(negedge clk_i);
                    check("stall_valid", valid_o, 1);
                    check("stall_data", data_o, exp0);
                end
                flush_i = 1'b0;
            end
            yumi_i = 1'b1;
            @(posedge clk_i);
        end
        @(negedge clk_i);
        yumi_i = 1'b0;
        #1;
        check("valid_after_drain", valid_o, 0);
        check("ready_after_drain", ready_o, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        //           a  b  words mode val gap hold abort full
        cases[0] = '{1, 5, 128, 1, 0,   0, 0, 0,  1'b1};  // identity
        cases[1] = '{2, 2, 128, 0, 8,   0, 0, 0,  1'b0};  // all ones
        cases[2] = '{3, 3, 128, 0, 8,   0, 0, 0,  1'b0};  // 255s wrap to 0x08
        cases[3] = '{4, 5, 64,  0, 0,   0, 0, 0,  1'b0};  // A only, B stays zero
        cases[4] = '{1, 5, 128, 1, 0,   0, 5, 0,  1'b0};  // yumi stall + ignored flush
        cases[5] = '{1, 5, 128, 1, 0,   3, 0, 0,  1'b0};  // en_i gap in compute
        cases[6] = '{6, 5, 128, 2, 0,   0, 0, 0,  1'b0};  // general product
        cases[7] = '{1, 5, 128, 1, 0,   0, 0, 10, 1'b0};  // reset after 10 outputs
        cases[8] = '{1, 5, 128, 1, 0,   0, 0, 0,  1'b0};  // fresh run after reset
        cases[9] = '{6, 5, 100, 2, 0,   0, 0, 0,  1'b0};  // B partly loaded

        reset_i = 1'b0;
        en_i    = 1'b1;
        flush_i = 1'b0;
        valid_i = 1'b0;
        data_i  = '0;
        yumi_i  = 1'b0;
        #12;
        check("reset_ready", ready_o, 0);
        check("reset_valid", valid_o, 0);
        check("reset_data", data_o, 0);
        @(negedge clk_i);
        reset_i = 1'b1;
        #1;
        check("ready_after_release", ready_o, 1);

        for (int t = 0; t < 10; t++) run_case(cases[t]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
